// File: rtl/conv_psum_accumulator.sv
// Per-pixel cross-channel partial-sum accumulator with bias add and DWIDTH saturation.
// Optional feature macro PSUM_SAT_CNT_EN adds a per-frame count of clamped outputs (sat_count).
module conv_psum_accumulator #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 24,
    parameter int DEPTH  = 784,
    parameter int CWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        featmap_size,
    input  logic [CWIDTH-1:0] num_channels,
    input  logic [DWIDTH-1:0] bias,
    input  logic              psum_valid,
    input  logic [DWIDTH-1:0] psum,
    output logic              psum_ready,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
`ifdef PSUM_SAT_CNT_EN
    output logic [15:0]       sat_count,
`endif
    output logic              done
);

    localparam int PWIDTH = $clog2(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [CWIDTH-1:0] C_ZERO = {CWIDTH{1'b0}};
    localparam logic [CWIDTH-1:0] C_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [PWIDTH-1:0] P_ZERO = {PWIDTH{1'b0}};
    localparam logic [PWIDTH-1:0] P_ONE  = {{(PWIDTH-1){1'b0}}, 1'b1};

    localparam logic signed [AWIDTH-1:0] SAT_MAX = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] SAT_MIN = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] D_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] D_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    function automatic logic sat_hit_fn(input logic signed [AWIDTH-1:0] v);
        sat_hit_fn = (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic [DWIDTH-1:0] sat_fn(input logic signed [AWIDTH-1:0] v);
        if (v > SAT_MAX) begin
            sat_fn = D_MAX;
        end else if (v < SAT_MIN) begin
            sat_fn = D_MIN;
        end else begin
            sat_fn = v[DWIDTH-1:0];
        end
    endfunction

    logic signed [AWIDTH-1:0] acc_mem [DEPTH];

    logic [0:0]               state_r;
    logic [PWIDTH-1:0]        npix_m1_r;
    logic [CWIDTH-1:0]        clast_r;
    logic [DWIDTH-1:0]        bias_r;
    logic [PWIDTH-1:0]        pix_r;
    logic [CWIDTH-1:0]        ch_r;
    logic                     last_issued_r;
    logic [DWIDTH-1:0]        dout_r;
    logic                     dout_valid_r;
    logic                     busy_r;
    logic                     done_r;
    logic [15:0]              sat_count_r;

    logic                     psum_ready_s;
    logic                     psum_xfer_s;
    logic                     dout_xfer_s;
    logic                     is_first_s;
    logic                     is_last_s;
    logic                     pix_end_s;
    logic [4:0]               n_eff_s;
    logic [CWIDTH-1:0]        c_eff_s;
    logic [PWIDTH-1:0]        npix_s;
    logic signed [AWIDTH-1:0] psum_ext_s;
    logic signed [AWIDTH-1:0] bias_ext_s;
    logic signed [AWIDTH-1:0] acc_rd_s;
    logic signed [AWIDTH-1:0] base_s;
    logic signed [AWIDTH-1:0] part_s;
    logic signed [AWIDTH-1:0] sum_s;
    logic                     mem_we_s;

    assign psum_ready_s = (state_r == ACCUM) & ~last_issued_r & (~dout_valid_r | dout_ready);
    assign psum_xfer_s  = psum_valid & psum_ready_s;
    assign dout_xfer_s  = dout_valid_r & dout_ready;
    assign is_first_s   = (ch_r == C_ZERO);
    assign is_last_s    = (ch_r == clast_r);
    assign pix_end_s    = (pix_r == npix_m1_r);
    assign psum_ext_s   = signed'({{(AWIDTH-DWIDTH){psum[DWIDTH-1]}}, psum});
    assign bias_ext_s   = signed'({{(AWIDTH-DWIDTH){bias_r[DWIDTH-1]}}, bias_r});
    assign acc_rd_s     = acc_mem[pix_r];

    // Frame geometry from the start-time inputs; zero sizes fall back to one.
    always_comb begin
        n_eff_s = featmap_size;
        c_eff_s = num_channels;
        if (featmap_size == 5'd0) begin
            n_eff_s = 5'd1;
        end else begin
            n_eff_s = featmap_size;
        end
        if (num_channels == C_ZERO) begin
            c_eff_s = C_ONE;
        end else begin
            c_eff_s = num_channels;
        end
        npix_s = PWIDTH'(n_eff_s) * PWIDTH'(n_eff_s);
    end

    // Channel 0 starts from zero so stale array contents never leak into a new frame.
    always_comb begin
        base_s   = acc_rd_s;
        if (is_first_s) begin
            base_s = {AWIDTH{1'b0}};
        end else begin
            base_s = acc_rd_s;
        end
        part_s   = base_s + psum_ext_s;
        sum_s    = part_s + bias_ext_s;
        mem_we_s = psum_xfer_s & ~is_last_s;
    end

    // Accumulator array write port; contents intentionally have no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            acc_mem[pix_r] <= part_s;
        end
    end

    // Control FSM, counters and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            npix_m1_r     <= P_ZERO;
            clast_r       <= C_ZERO;
            bias_r        <= {DWIDTH{1'b0}};
            pix_r         <= P_ZERO;
            ch_r          <= C_ZERO;
            last_issued_r <= 1'b0;
            dout_r        <= {DWIDTH{1'b0}};
            dout_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sat_count_r   <= 16'h0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r       <= ACCUM;
                        npix_m1_r     <= npix_s - P_ONE;
                        clast_r       <= c_eff_s - C_ONE;
                        bias_r        <= bias;
                        pix_r         <= P_ZERO;
                        ch_r          <= C_ZERO;
                        last_issued_r <= 1'b0;
                        busy_r        <= 1'b1;
                        sat_count_r   <= 16'h0000;
                    end
                end
                ACCUM: begin
                    if (psum_xfer_s) begin
                        if (pix_end_s) begin
                            pix_r <= P_ZERO;
                            if (is_last_s) begin
                                last_issued_r <= 1'b1;
                            end else begin
                                ch_r <= ch_r + C_ONE;
                            end
                        end else begin
                            pix_r <= pix_r + P_ONE;
                        end
                    end
                    if (psum_xfer_s && is_last_s) begin
                        dout_r       <= sat_fn(sum_s);
                        dout_valid_r <= 1'b1;
                        if (sat_hit_fn(sum_s) && (sat_count_r != 16'hFFFF)) begin
                            sat_count_r <= sat_count_r + 16'd1;
                        end
                    end else if (dout_xfer_s) begin
                        dout_valid_r <= 1'b0;
                    end
                    // Only the final dout can still be pending once every psum is issued.
                    if (dout_xfer_s && last_issued_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign psum_ready = psum_ready_s;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef PSUM_SAT_CNT_EN
    assign sat_count  = sat_count_r;
`endif

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Self-checking bench for conv_psum_accumulator: directed scenarios plus randomized frames
// compared against a per-pixel arithmetic reference model.
module tb_conv_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  featmap_size;
    logic [5:0]  num_channels;
    logic [15:0] bias;
    logic        psum_valid;
    logic [15:0] psum;
    logic        psum_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
`ifdef PSUM_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    int errors = 0;
    int checks = 0;
    int psum_q[$];

    always #5 clk = ~clk;

    conv_psum_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .featmap_size (featmap_size),
        .num_channels (num_channels),
        .bias         (bias),
        .psum_valid   (psum_valid),
        .psum         (psum),
        .psum_ready   (psum_ready),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .busy         (busy),
`ifdef PSUM_SAT_CNT_EN
        .sat_count    (sat_count),
`endif
        .done         (done)
    );

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // kind 0: small signed values, kind 1: full 16-bit signed range
    task automatic fill_random(input int count, input int kind);
        int v;
        psum_q.delete();
        for (int i = 0; i < count; i++) begin
            if (kind == 0) v = int'($urandom_range(0, 4000)) - 2000;
            else begin
                v = int'($urandom_range(0, 65535));
                if (v > 32767) v = v - 65536;
            end
            psum_q.push_back(v);
        end
    endtask

    // rmode 0: dout_ready=1, 1: random valid/ready, 2: hold ready low 5 cycles at first dout
    task automatic run_frame(input int n, input int c, input int b, input int rmode,
                             input bit inj_start, input int abort_at);
        int npix, ceff, total, in_idx, out_idx, stall, exp_sat, budget;
        int exp_q[$];
        bit dv_m, px, dx, fin, exp_pr;
        longint acc;
        npix = n * n;
        ceff = (c == 0) ? 1 : c;
        total = npix * ceff;
        exp_sat = 0;
        for (int p = 0; p < npix; p++) begin
            acc = b;
            for (int k = 0; k < ceff; k++) acc += psum_q[k * npix + p];
            if (acc > 32767 || acc < -32768) exp_sat++;
            exp_q.push_back(sat16(acc));
        end
        @(negedge clk);
        featmap_size = 5'(n);
        num_channels = 6'(c);
        bias = 16'(b);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        in_idx = 0; out_idx = 0; stall = 0; dv_m = 1'b0; fin = 1'b0;
        budget = total * 30 + 200;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            if (abort_at >= 0 && in_idx >= abort_at) begin
                psum_valid = 1'b0;
                return;
            end
            psum_valid = (in_idx < total) && (rmode != 1 || $urandom_range(0, 3) != 0);
            psum = (in_idx < total) ? 16'(psum_q[in_idx]) : 16'($urandom);
            case (rmode)
                1: dout_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (dv_m && stall < 5) begin
                        dout_ready = 1'b0;
                        stall++;
                    end else dout_ready = 1'b1;
                end
                default: dout_ready = 1'b1;
            endcase
            if (inj_start) begin
                start = (in_idx == 2);
                featmap_size = (in_idx == 2) ? 5'(n + 1) : 5'(n);
                num_channels = (in_idx == 2) ? 6'(c + 1) : 6'(c);
            end
            #1;
            exp_pr = (in_idx < total) && (!dv_m || dout_ready);
            checks++;
            if (psum_ready !== exp_pr) begin
                errors++;
                $display("FAIL psum_ready: got %b want %b (in %0d out %0d)", psum_ready, exp_pr, in_idx, out_idx);
            end
            checks++;
            if (dout_valid !== dv_m) begin
                errors++;
                $display("FAIL dout_valid: got %b want %b (in %0d out %0d)", dout_valid, dv_m, in_idx, out_idx);
            end
            if (dv_m && out_idx < npix) begin
                checks++;
                if (dout !== 16'(exp_q[out_idx])) begin
                    errors++;
                    $display("FAIL dout[%0d]: got %h want %h", out_idx, dout, 16'(exp_q[out_idx]));
                end
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_early: got %b want 0", done);
            end
            px = psum_valid && psum_ready;
            dx = dv_m && dout_ready;
            if (dx) begin
                out_idx++;
                if (out_idx == npix) fin = 1'b1;
            end
            dv_m = (px && (in_idx / npix) == ceff - 1) ? 1'b1 : (dx ? 1'b0 : dv_m);
            if (px) in_idx++;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        dout_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL frame_timeout: got %0d douts want %0d", out_idx, npix);
        end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL frame_end: got done=%b busy=%b dv=%b want 1 0 0", done, busy, dout_valid);
            end
`ifdef PSUM_SAT_CNT_EN
            checks++;
            if (sat_count !== 16'(exp_sat)) begin
                errors++;
                $display("FAIL sat_count: got %0d want %0d", sat_count, exp_sat);
            end
`endif
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: got %b want 0", done);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (psum_ready !== 1'b0 || dout !== 16'h0000 || dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got pr=%b dout=%h dv=%b busy=%b done=%b want all 0",
                     tag, psum_ready, dout, dout_valid, busy, done);
        end
`ifdef PSUM_SAT_CNT_EN
        checks++;
        if (sat_count !== 16'h0000) begin
            errors++;
            $display("FAIL %s_sat_count: got %0d want 0", tag, sat_count);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; featmap_size = 5'd0; num_channels = 6'd0; bias = 16'h0000;
        psum_valid = 1'b0; psum = 16'h0000; dout_ready = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        psum_q = '{1, 2, 3, 4};
        run_frame(2, 1, 3, 0, 1'b0, -1);
    endtask

    task automatic test_multi_channel();
        psum_q = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400};
        run_frame(2, 3, 0, 0, 1'b0, -1);
    endtask

    task automatic test_saturation();
        psum_q = '{28672, 28672};
        run_frame(1, 2, 256, 0, 1'b0, -1);
        psum_q = '{-28672, -28672};
        run_frame(1, 2, -256, 0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        psum_q = '{7, -8, 9, -10};
        run_frame(2, 1, 5, 2, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        fill_random(3 * 3 * 2, 0);
        run_frame(3, 2, 11, 0, 1'b1, -1);
    endtask

    task automatic test_idle_psum();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            psum_valid = 1'b1;
            psum = 16'(i + 1);
            dout_ready = 1'b1;
            #1;
            checks++;
            if (psum_ready !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_psum: got pr=%b dv=%b busy=%b want 0 0 0", psum_ready, dout_valid, busy);
            end
        end
        psum_valid = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        fill_random(28 * 28 * 6, 1);
        run_frame(28, 6, 0, 0, 1'b0, 28 * 28 + 20);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_ch1");
        rst = 1'b0;
        psum_q = '{-5, 6, 100, 32767};
        run_frame(2, 1, 1, 0, 1'b0, -1);
        psum_q = '{1000, 2000, 3000, 4000};
        run_frame(2, 1, 0, 0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_inflight_dout");
        rst = 1'b0;
        psum_q = '{3, 4, 5, 6, 7, 8, 9, 10};
        run_frame(2, 2, -2, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        int n, c, ceff, b;
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(1, 5));
            c = int'($urandom_range(0, 4));
            ceff = (c == 0) ? 1 : c;
            b = int'($urandom_range(0, 8000)) - 4000;
            fill_random(n * n * ceff, int'($urandom_range(0, 1)));
            run_frame(n, c, b, 1, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_saturation();
        test_backpressure();
        test_start_ignored();
        test_idle_psum();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
